// File: rtl/addr8u_share_ctrl.sv
// Round-robin sequencer sharing one 8-bit unsigned adder among NREQ requesters.
// Optional time-redundant execution with compare/retry: define ADDR8U_DUAL_EXEC_EN.
module addr8u_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    input  logic [8:0]        add_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [8:0]        rsp_sum,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {StIdle, StExec1, StExec2, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    last_grant_q;
    logic [IDW-1:0]    id_q;
    logic [7:0]        a_q, b_q;
    logic [8:0]        sum_q;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic [7:0]        sel_a, sel_b;
    logic              transfer;

`ifdef ADDR8U_DUAL_EXEC_EN
    logic [8:0]        s1_q;
    logic              retry_q;
    logic              rsp_err_q;
    logic [7:0]        err_count_q;
    logic              mismatch;

    assign mismatch  = (add_s != s1_q);
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
`else
    assign rsp_err   = 1'b0;
    assign err_count = 8'h00;
`endif

    // First valid requester after the last grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDW'((int'(last_grant_q) + k) % int'(NREQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a = 8'h00;
        sel_b = 8'h00;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*8 +: 8];
                sel_b = req_b[i*8 +: 8];
            end
        end
    end

    assign transfer = (state_q == StIdle) && grant_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_found) state_d = StExec1;
`ifdef ADDR8U_DUAL_EXEC_EN
            StExec1: state_d = StExec2;
            StExec2: state_d = (!mismatch || retry_q) ? StResp : StExec1;
`else
            StExec1: state_d = StResp;
            StExec2: state_d = StIdle;
`endif
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Adder inputs held at zero outside execution so the shared core stays quiet.
    always_comb begin
        req_ready = '0;
        add_a     = 8'h00;
        add_b     = 8'h00;
        case (state_q)
            StIdle:  if (grant_found) req_ready[grant_idx] = 1'b1;
            StExec1: begin
                add_a = a_q;
                add_b = b_q;
            end
            StExec2: begin
                add_a = b_q;
                add_b = a_q;
            end
            default: ;
        endcase
    end

    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            sum_q        <= 9'h000;
`ifdef ADDR8U_DUAL_EXEC_EN
            s1_q         <= 9'h000;
            retry_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_count_q  <= 8'h00;
`endif
        end else begin
            if (transfer) begin
                a_q          <= sel_a;
                b_q          <= sel_b;
                id_q         <= grant_idx;
                last_grant_q <= grant_idx;
`ifdef ADDR8U_DUAL_EXEC_EN
                retry_q      <= 1'b0;
                rsp_err_q    <= 1'b0;
`endif
            end
`ifdef ADDR8U_DUAL_EXEC_EN
            if (state_q == StExec1) s1_q <= add_s;
            if (state_q == StExec2) begin
                if (!mismatch) begin
                    sum_q     <= s1_q;
                    rsp_err_q <= 1'b0;
                end else begin
                    if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                    if (retry_q) begin
                        sum_q     <= add_s;
                        rsp_err_q <= 1'b1;
                    end else begin
                        retry_q   <= 1'b1;
                    end
                end
            end
`else
            if (state_q == StExec1) sum_q <= add_s;
`endif
        end
    end

endmodule

// File: tb/tb_addr8u_share_ctrl.sv
// Directed bench for addr8u_share_ctrl; fault-injection cases run when
// ADDR8U_DUAL_EXEC_EN is defined.
module tb_addr8u_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = 32'h01FF803C;
    logic [31:0] req_b = 32'h02FF8045;
    logic [7:0]  add_a, add_b;
    logic [8:0]  add_s;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_sum;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] inj_mode = 2'd0;
    logic       inj_done;

`ifdef ADDR8U_DUAL_EXEC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    addr8u_share_ctrl #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_count (err_count)
    );

    // Shared adder model; mode 1 corrupts the swapped pass, mode 2 the first straight pass.
    always_comb begin
        add_s = {1'b0, add_a} + {1'b0, add_b};
        if (inj_mode == 2'd1 && add_a == 8'h34 && add_b == 8'h12) add_s[0] = ~add_s[0];
        if (inj_mode == 2'd2 && !inj_done && add_a == 8'h12 && add_b == 8'h34)
            add_s[0] = ~add_s[0];
    end

    always @(posedge clk) begin
        if (inj_mode == 2'd0) inj_done <= 1'b0;
        else if (inj_mode == 2'd2 && add_a == 8'h12 && add_b == 8'h34) inj_done <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] mask, input int idx, input int lat,
                          input logic [8:0] sum, input logic err);
        int cyc;
        @(negedge clk);
        req_valid = mask;
        #1;
        check_eq("grant", {28'd0, req_ready}, 32'd1 << idx);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            req_valid = '0;
            cyc++;
        end while (!rsp_valid && cyc < 20);
        check_eq("latency", cyc, lat);
        check_eq("rsp_id", {30'd0, rsp_id}, idx);
        check_eq("rsp_sum", {23'd0, rsp_sum}, {23'd0, sum});
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        logic [8:0] rr_sum [4];
        rr_sum[0] = 9'h081;
        rr_sum[1] = 9'h100;
        rr_sum[2] = 9'h1FE;
        rr_sum[3] = 9'h003;

        do_reset();
        @(negedge clk);
        check_eq("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        check_eq("rst_rsp_sum", {23'd0, rsp_sum}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        check_eq("rst_add", {16'd0, add_a, add_b}, 32'd0);

        run_op(4'b0001, 0, LAT, 9'h081, 1'b0);
        run_op(4'b0100, 2, LAT, 9'h1FE, 1'b0);

        // Withdrawn request: offered, then dropped before the edge.
        @(negedge clk);
        req_valid = 4'b0010;
        #1 check_eq("wd_ready", {28'd0, req_ready}, 32'h2);
        #2 req_valid = '0;
        @(posedge clk);
        #1;
        check_eq("wd_busy", {31'd0, busy}, 32'd0);
        check_eq("wd_ready0", {28'd0, req_ready}, 32'd0);
        run_op(4'b1111, 3, LAT, 9'h003, 1'b0);

        do_reset();
        for (int i = 0; i < 5; i++) run_op(4'b1111, i % 4, LAT, rr_sum[i % 4], 1'b0);

        // Backpressure on the response channel.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0010;
        #1 check_eq("bp_grant", {28'd0, req_ready}, 32'h2);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            req_valid = 4'b1111;
            cyc++;
        end while (!rsp_valid && cyc < 20);
        check_eq("bp_latency", cyc, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_id", {30'd0, rsp_id}, 32'd1);
            check_eq("bp_sum", {23'd0, rsp_sum}, 32'h100);
            check_eq("bp_ready", {28'd0, req_ready}, 32'd0);
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        check_eq("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_rel_busy", {31'd0, busy}, 32'd0);

        // Reset while executing.
        @(negedge clk);
        req_valid = 4'b1000;
        #1 check_eq("mr_grant", {28'd0, req_ready}, 32'h8);
        @(posedge clk);
        #1;
        req_valid = '0;
        check_eq("mr_add", {16'd0, add_a, add_b}, 32'h0102);
        check_eq("mr_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mr_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mr_busy0", {31'd0, busy}, 32'd0);
        check_eq("mr_sum", {23'd0, rsp_sum}, 32'd0);
        check_eq("mr_add0", {16'd0, add_a, add_b}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_eq("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_op(4'b1111, 0, LAT, 9'h081, 1'b0);

`ifdef ADDR8U_DUAL_EXEC_EN
        req_a = 32'h01FF8012;
        req_b = 32'h02FF8034;
        inj_mode = 2'd0;
        do_reset();
        inj_mode = 2'd1;
        run_op(4'b0001, 0, 5, 9'h047, 1'b1);
        check_eq("inj2_err_count", {24'd0, err_count}, 32'd2);
        inj_mode = 2'd0;
        do_reset();
        inj_mode = 2'd2;
        run_op(4'b0001, 0, 5, 9'h046, 1'b0);
        check_eq("inj1_err_count", {24'd0, err_count}, 32'd1);
        inj_mode = 2'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
